// File: rtl/auto_player_pkg.sv
// auto_player_pkg: note codes, FSM state encoding and width helpers shared by the player and its ROM
package auto_player_pkg;
  localparam int REST = 0;
  localparam int NOTE_C = 1;
  localparam int NOTE_D = 2;
  localparam int NOTE_E = 3;
  localparam int NOTE_F = 4;
  localparam int NOTE_G = 5;
  localparam int NOTE_A = 6;
  localparam int NOTE_B = 7;
  typedef enum logic [2:0] {S_FETCH, S_LATCH, S_PLAY, S_PAUSE, S_DONE} state_t;
  function automatic int end_code(input int w);
    return (1 << w) - 1;
  endfunction
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/song_rom.sv
// song_rom: synchronous one-cycle-read table of {note, duration} per song slot; unlisted slots read END
module song_rom import auto_player_pkg::*; #(
  parameter int NUM_SONGS = 3,
  parameter int SONG_LEN = 56,
  parameter int NOTE_W = 4,
  parameter int DUR_W = 4
) (
  input  logic                    clk,
  input  logic [cw(NUM_SONGS)-1:0] song,
  input  logic [cw(SONG_LEN)-1:0]  pos,
  output logic [NOTE_W-1:0]        note,
  output logic [DUR_W-1:0]         dur
);
  logic [NOTE_W+DUR_W-1:0] e;
  function automatic logic [NOTE_W+DUR_W-1:0] mk(input int n, input int d);
    return {NOTE_W'(n), DUR_W'(d)};
  endfunction
  always_comb begin
    e = mk(end_code(NOTE_W), 0);
    case (int'(song))
      0: case (int'(pos))
        0: e = mk(NOTE_E, 2);
        1: e = mk(NOTE_C, 1);
        2: e = mk(NOTE_D, 0);
        3: e = mk(NOTE_G, 3);
        4: e = mk(REST, 1);
        5: e = mk(NOTE_B, 2);
        6: e = mk(NOTE_F, 1);
        7: e = mk(NOTE_A, 1);
        default: ;
      endcase
      1: case (int'(pos))
        0: e = mk(NOTE_C, 1);
        1: e = mk(NOTE_D, 1);
        2: e = mk(NOTE_E, 1);
        3: e = mk(NOTE_F, 1);
        default: ;
      endcase
      2: case (int'(pos))
        0: e = mk(NOTE_B, 1);
        1: e = mk(NOTE_A, 2);
        2: e = mk(NOTE_G, 1);
        3: e = mk(NOTE_F, 1);
        4: e = mk(NOTE_E, 2);
        5: e = mk(NOTE_D, 1);
        6: e = mk(NOTE_C, 1);
        7: e = mk(NOTE_G, 1);
        default: ;
      endcase
      default: ;
    endcase
  end
  always_ff @(posedge clk) {note, dur} <= e;
endmodule

// File: rtl/auto_player.sv
// auto_player: ROM-driven melody sequencer with pause, looping and next/previous song select
module auto_player import auto_player_pkg::*; #(
  parameter int NUM_SONGS = 3,
  parameter int SONG_LEN = 56,
  parameter int NOTE_W = 4,
  parameter int DUR_W = 4,
  parameter int TICK_DIV = 10_000_000,
  parameter int LED_W = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     next_song,
  input  logic                     prev_song,
  input  logic                     pause,
  input  logic                     loop_en,
  output logic [NOTE_W-1:0]        note_to_play,
  output logic [LED_W-1:0]         led_out,
  output logic [cw(NUM_SONGS)-1:0] song_idx,
  output logic                     playing,
  output logic                     song_done
);
  localparam int SW = cw(NUM_SONGS);
  localparam int PW = cw(SONG_LEN);
  localparam int TW = cw(TICK_DIV);
  state_t state_q, state_d;
  logic [SW-1:0] song_q, song_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [DUR_W-1:0] beat_q, beat_d, dur_q, dur_d, rom_dur;
  logic [NOTE_W-1:0] note_q, note_d, out_q, out_d, rom_note;
  logic [LED_W-1:0] led_q, led_d;
  logic done_q, done_d, next_q, prev_q, loop_q;
  logic nxt_e, prv_e, sel, tick_wrap, expire, fin;
  song_rom #(.NUM_SONGS(NUM_SONGS), .SONG_LEN(SONG_LEN), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) u_rom (
    .clk(clk), .song(song_q), .pos(pos_q), .note(rom_note), .dur(rom_dur)
  );
  assign nxt_e = next_song & ~next_q;
  assign prv_e = prev_song & ~prev_q;
  assign sel = nxt_e ^ prv_e;
  assign tick_wrap = tick_q == TW'(TICK_DIV - 1);
  assign expire = tick_wrap && beat_q == dur_q - 1'b1;
  always_comb begin
    state_d = state_q;
    song_d = song_q;
    pos_d = pos_q;
    tick_d = tick_q;
    beat_d = beat_q;
    note_d = note_q;
    dur_d = dur_q;
    fin = 1'b0;
    if (sel) begin
      song_d = nxt_e ? (song_q == SW'(NUM_SONGS - 1) ? '0 : song_q + 1'b1)
                     : (song_q == '0 ? SW'(NUM_SONGS - 1) : song_q - 1'b1);
      pos_d = '0;
      tick_d = '0;
      beat_d = '0;
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: state_d = S_LATCH;
        S_LATCH: begin
          note_d = rom_note;
          dur_d = rom_dur == '0 ? DUR_W'(1) : rom_dur;
          tick_d = '0;
          beat_d = '0;
          fin = &rom_note;
          state_d = S_PLAY;
        end
        S_PLAY: begin
          tick_d = tick_wrap ? '0 : tick_q + 1'b1;
          beat_d = expire ? '0 : beat_q + DUR_W'(tick_wrap);
          fin = expire && pos_q == PW'(SONG_LEN - 1);
          pos_d = expire && !fin ? pos_q + 1'b1 : pos_q;
          state_d = expire ? S_FETCH : pause ? S_PAUSE : S_PLAY;
        end
        S_PAUSE: state_d = pause ? S_PAUSE : S_PLAY;
        S_DONE: begin
          pos_d = loop_en && !loop_q ? '0 : pos_q;
          state_d = loop_en && !loop_q ? S_FETCH : S_DONE;
        end
        default: state_d = S_FETCH;
      endcase
      // end of song: an END code or the last slot finishing
      if (fin) begin
        pos_d = loop_en ? '0 : pos_q;
        state_d = loop_en ? S_FETCH : S_DONE;
      end
    end
    out_d = state_d == S_PLAY ? note_d : '0;
    led_d = (out_d != '0 && int'(out_d) <= LED_W) ? LED_W'(1) << (out_d - 1'b1) : '0;
    done_d = state_d == S_DONE && state_q != S_DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      song_q <= '0;
      pos_q <= '0;
      tick_q <= '0;
      beat_q <= '0;
      note_q <= '0;
      dur_q <= '0;
      out_q <= '0;
      led_q <= '0;
      done_q <= 1'b0;
      next_q <= 1'b0;
      prev_q <= 1'b0;
      loop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      song_q <= song_d;
      pos_q <= pos_d;
      tick_q <= tick_d;
      beat_q <= beat_d;
      note_q <= note_d;
      dur_q <= dur_d;
      out_q <= out_d;
      led_q <= led_d;
      done_q <= done_d;
      next_q <= next_song;
      prev_q <= prev_song;
      loop_q <= loop_en;
    end
  end
  assign note_to_play = out_q;
  assign led_out = led_q;
  assign song_idx = song_q;
  assign playing = state_q == S_PLAY;
  assign song_done = done_q;
endmodule

// File: tb/tb_auto_player.sv
// tb_auto_player: vector table, directed select/end sequences and random stimulus against a note-timeline model
module tb_auto_player;
  localparam int NS = 3, SL = 8, TD = 4, ENDN = 15;
  logic clk = 1'b0, reset = 1'b1, next_song = 1'b0, prev_song = 1'b0, pause = 1'b0, loop_en = 1'b0;
  logic [3:0] note_to_play;
  logic [6:0] led_out;
  logic [1:0] song_idx;
  logic playing, song_done;
  int vectors = 0, miscompares = 0;
  int rn [3][8] = '{'{3, 1, 2, 5, 0, 7, 4, 6}, '{1, 2, 3, 4, 15, 15, 15, 15}, '{7, 6, 5, 4, 3, 2, 1, 5}};
  int rd [3][8] = '{'{2, 1, 0, 3, 1, 2, 1, 1}, '{1, 1, 1, 1, 0, 0, 0, 0}, '{1, 2, 1, 1, 2, 1, 1, 1}};
  int m_mode = 0, m_gap = 2, m_rem = 0, m_song = 0, m_slot = 0;
  bit m_pn = 0, m_pp = 0, m_pl = 0, m_pulse = 0;
  typedef struct {
    bit r, pa;
    logic [3:0] note;
    logic [6:0] led;
    bit play;
  } vec_t;
  vec_t tv[$];

  auto_player #(.NUM_SONGS(NS), .SONG_LEN(SL), .NOTE_W(4), .DUR_W(4), .TICK_DIV(TD), .LED_W(7)) dut (
    .clk(clk), .reset(reset), .next_song(next_song), .prev_song(prev_song), .pause(pause),
    .loop_en(loop_en), .note_to_play(note_to_play), .led_out(led_out), .song_idx(song_idx),
    .playing(playing), .song_done(song_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mode: 0 fetch gap, 1 sounding, 2 paused, 3 done
  task automatic model_end(input bit lp);
    if (lp) begin
      m_slot = 0;
      m_mode = 0;
      m_gap = 2;
    end else begin
      m_mode = 3;
      m_pulse = 1;
    end
  endtask

  task automatic step(input string tag);
    bit r, n, p, pa, lp, ne, pe, lr;
    int en, el, d;
    r = reset; n = next_song; p = prev_song; pa = pause; lp = loop_en;
    @(posedge clk);
    m_pulse = 0;
    if (r) begin
      m_song = 0; m_slot = 0; m_mode = 0; m_gap = 2;
      m_pn = 0; m_pp = 0; m_pl = 0;
    end else begin
      ne = n && !m_pn;
      pe = p && !m_pp;
      lr = lp && !m_pl;
      m_pn = n; m_pp = p; m_pl = lp;
      if (ne != pe) begin
        m_song = (m_song + (ne ? 1 : NS - 1)) % NS;
        m_slot = 0; m_mode = 0; m_gap = 2;
      end else begin
        case (m_mode)
          0: begin
            m_gap -= 1;
            if (m_gap == 0) begin
              if (rn[m_song][m_slot] == ENDN) model_end(lp);
              else begin
                d = rd[m_song][m_slot];
                m_mode = 1;
                m_rem = (d == 0 ? 1 : d) * TD;
              end
            end
          end
          1: begin
            m_rem -= 1;
            if (m_rem == 0) begin
              if (m_slot == SL - 1) model_end(lp);
              else begin
                m_slot += 1; m_mode = 0; m_gap = 2;
              end
            end else if (pa) m_mode = 2;
          end
          2: if (!pa) m_mode = 1;
          default: if (lr) begin
            m_slot = 0; m_mode = 0; m_gap = 2;
          end
        endcase
      end
    end
    #1;
    en = m_mode == 1 ? rn[m_song][m_slot] : 0;
    el = (en >= 1 && en <= 7) ? (1 << (en - 1)) : 0;
    chk(tag, {17'd0, note_to_play, led_out, song_idx, playing, song_done},
        {17'd0, 4'(en), 7'(el), 2'(m_song), m_mode == 1, m_pulse});
  endtask

  task automatic add(input int cnt, input bit r, input bit pa, input logic [3:0] note,
                     input logic [6:0] led, input bit play);
    vec_t v;
    v.r = r; v.pa = pa; v.note = note; v.led = led; v.play = play;
    for (int i = 0; i < cnt; i++) tv.push_back(v);
  endtask

  initial begin
    add(2, 1, 0, 0, 7'b0000000, 0);
    add(1, 0, 0, 0, 7'b0000000, 0);
    add(8, 0, 0, 3, 7'b0000100, 1);
    add(2, 0, 0, 0, 7'b0000000, 0);
    add(1, 0, 0, 1, 7'b0000001, 1);
    add(5, 0, 1, 0, 7'b0000000, 0);
    add(3, 0, 0, 1, 7'b0000001, 1);
    add(2, 0, 0, 0, 7'b0000000, 0);
    add(4, 0, 0, 2, 7'b0000010, 1);
    add(2, 0, 0, 0, 7'b0000000, 0);
    add(2, 0, 0, 5, 7'b0010000, 1);
    add(1, 1, 0, 0, 7'b0000000, 0);
    add(1, 0, 0, 0, 7'b0000000, 0);
    add(1, 0, 0, 3, 7'b0000100, 1);
    foreach (tv[i]) begin
      reset = tv[i].r;
      pause = tv[i].pa;
      step("model_tbl");
      chk($sformatf("table[%0d]", i), {17'd0, note_to_play, led_out, song_idx, playing, song_done},
          {17'd0, tv[i].note, tv[i].led, 2'd0, tv[i].play, 1'b0});
    end
    next_song = 1; prev_song = 1;
    step("both_sel");
    chk("both_sel_ignored", {song_idx, note_to_play, playing}, {2'd0, 4'd3, 1'b1});
    next_song = 0; prev_song = 0;
    step("both_rel");
    prev_song = 1;
    step("prev");
    chk("prev_wrap", {song_idx, note_to_play}, {2'd2, 4'd0});
    prev_song = 0;
    step("prev_latch");
    step("prev_play");
    chk("song2_note", {song_idx, note_to_play}, {2'd2, 4'd7});
    next_song = 1;
    step("next");
    chk("next_wrap", {song_idx, note_to_play, playing}, {2'd0, 4'd0, 1'b0});
    next_song = 0;
    step("next_latch");
    step("next_play");
    chk("next_new_note", {song_idx, note_to_play}, {2'd0, 4'd3});
    next_song = 1;
    step("to_song1");
    next_song = 0;
    for (int i = 0; i < 100 && !song_done; i++) step("wait_done");
    chk("done_seen", song_done, 1);
    chk("done_outputs", {note_to_play, led_out, playing}, 0);
    step("done_hold");
    chk("done_pulse_width", {song_done, note_to_play, playing}, 0);
    for (int i = 0; i < 3; i++) step("done_idle");
    loop_en = 1;
    step("loop_rise");
    step("loop_latch");
    step("loop_play");
    chk("loop_replay", {song_idx, note_to_play, playing}, {2'd1, 4'd1, 1'b1});
    loop_en = 0;
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 29) == 0) next_song = ~next_song;
      if ($urandom_range(0, 29) == 0) prev_song = ~prev_song;
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      if ($urandom_range(0, 59) == 0) loop_en = ~loop_en;
      step("random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
